// File: rtl/seq_shifter_pkg.sv
// Shared encodings for the sequential shifter: operation codes and FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_shifter_pkg;

  // Operation encoding on in_op.
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to hold a per-cycle shift distance of 0..step inclusive.
  function automatic int step_amt_w(input int step);
    return $clog2(step + 1);
  endfunction

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Purpose: one combinational shift step of up to STEP bit positions (SLL/SRL/SRA, optional ROL).
// Latency: combinational, 0 cycles.
// Backpressure: none; the enclosing FSM decides when the result is registered.
//
// Ports:
//   acc  in   WIDTH   value being shifted
//   k    in   KW      distance for this step, 0..STEP
//   op   in   2       operation code (seq_shifter_pkg OP_*)
//   res  out  WIDTH   acc shifted by k
//
// Build option: SEQ_SHIFTER_ROTATE_EN adds rotate-left for op 11; without it op 11 is SLL.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int KW   = step_amt_w(STEP)
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [KW-1:0]    k,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] res
);

`ifdef SEQ_SHIFTER_ROTATE_EN
  // Wide enough to hold WIDTH itself, so WIDTH-k never wraps.
  localparam int AW = $clog2(WIDTH) + 1;
  logic [AW-1:0] rk;

  // Complementary distance for the wrap-around half of a rotate. For k=0
  // this is WIDTH, and the right shift then contributes nothing.
  assign rk = AW'(WIDTH) - AW'(k);
`endif

  always_comb begin
    res = acc << k;
    case (op)
      OP_SRL: res = acc >> k;
      // Arithmetic shift replicates acc's MSB; since every step does so, the
      // sign of the original operand is preserved across the whole operation.
      OP_SRA: res = $unsigned($signed(acc) >>> k);
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROL: res = (acc << k) | (acc >> rk);
`endif
      default: res = acc << k;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Purpose: multi-cycle WIDTH-bit shifter (SLL/SRL/SRA, optional ROL) moving up to STEP bits per clock.
// Latency: ceil(shamt/STEP)+1 cycles from the accepting edge to out_valid; 1 cycle for shamt=0.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, then one IDLE cycle.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        request valid
//   in_ready   out  1        request accepted when high (IDLE only)
//   in_data    in   WIDTH    operand
//   in_shamt   in   SHAMT_W  shift amount 0..WIDTH-1
//   in_op      in   2        00 SLL, 01 SRL, 10 SRA, 11 ROL (or SLL without the rotate build)
//   out_valid  out  1        result valid, held until out_ready
//   out_ready  in   1        consumer takes the result
//   out_data   out  WIDTH    result; keeps its last value after hand-off
//
// Build option: SEQ_SHIFTER_ROTATE_EN enables op 11 as rotate left (passed through to shift_step).
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int  WIDTH   = 32,
  parameter int  STEP    = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  localparam int KW = step_amt_w(STEP);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   out_data_q;
  logic [WIDTH-1:0]   step_res;
  logic [SHAMT_W-1:0] cnt_q;
  logic [SHAMT_W-1:0] cnt_d;
  logic [1:0]         op_q;
  logic [KW-1:0]      k;

  // Distance for this cycle: k = min(STEP, cnt). The compare is done at int
  // width because STEP may equal WIDTH, which does not fit in SHAMT_W bits.
  always_comb begin
    k = KW'(cnt_q);
    if (int'(cnt_q) > STEP) begin
      k = KW'(STEP);
    end
  end

  // k never exceeds cnt, so the subtraction cannot underflow.
  assign cnt_d = cnt_q - SHAMT_W'(k);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .acc (acc_q),
    .k   (k),
    .op  (op_q),
    .res (step_res)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = (in_shamt != '0) ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (cnt_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath. out_data has its own register so it stays put after hand-off
  // and through the next operation's BUSY phase; it is only loaded on entry
  // to DONE, with the value acc takes on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      op_q       <= OP_SLL;
      out_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q <= in_data;
            cnt_q <= in_shamt;
            op_q  <= in_op;
            if (in_shamt == '0) begin
              out_data_q <= in_data;
            end
          end
        end
        BUSY: begin
          acc_q <= step_res;
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            out_data_q <= step_res;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data = out_data_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: three instances (STEP 1, 4, 32) driven one at a time,
// directed cases first, then random operations against a bit-level reference model.
// All driving and sampling happens on the falling clock edge.
module tb_seq_shifter;
  import seq_shifter_pkg::*;

  localparam int NRAND = 600;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] in_data   [3];
  logic [4:0]  in_shamt  [3];
  logic [1:0]  in_op     [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [31:0] out_data  [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    seq_shifter #(
      .WIDTH (32),
      .STEP  (g == 0 ? 1 : (g == 1 ? 4 : 32))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_shamt  (in_shamt[g]),
      .in_op     (in_op[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int step_of(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      default: return 32;
    endcase
  endfunction

  // Reference: whole shift done one bit position at a time.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] o);
    logic [31:0] r;
    r = d;
    for (int n = 0; n < s; n++) begin
      case (o)
        2'b01:   r = {1'b0, r[31:1]};
        2'b10:   r = {d[31], r[31:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
        2'b11:   r = {r[30:0], r[31]};
`endif
        default: r = {r[30:0], 1'b0};
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete operation on instance i. stall<0 picks a random hold time.
  task automatic run_op(input int i, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] o, input int stall, input string tag);
    logic [31:0] exp;
    int lat, explat, st;
    exp    = ref_shift(d, int'(s), o);
    explat = (int'(s) + step_of(i) - 1) / step_of(i) + 1;
    @(negedge clk);
    check({tag, " ready before accept"}, 32'(in_ready[i]), 32'd1);
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    in_shamt[i] = s;
    in_op[i]    = o;
    @(negedge clk);
    in_valid[i] = 1'b0;
    lat = 1;
    while (!out_valid[i] && lat < 64) begin
      check({tag, " ready low busy"}, 32'(in_ready[i]), 32'd0);
      // Junk on ignored inputs; out_ready has no effect outside DONE.
      in_data[i]   = $urandom;
      in_shamt[i]  = 5'($urandom);
      in_op[i]     = 2'($urandom);
      out_ready[i] = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    out_ready[i] = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(explat));
    check({tag, " result"}, out_data[i], exp);
    check({tag, " ready low done"}, 32'(in_ready[i]), 32'd0);
    st = (stall < 0) ? $urandom_range(0, 3) : stall;
    for (int c = 0; c < st; c++) begin
      @(negedge clk);
      check({tag, " valid held"}, 32'(out_valid[i]), 32'd1);
      check({tag, " data held"}, out_data[i], exp);
      check({tag, " ready low stall"}, 32'(in_ready[i]), 32'd0);
    end
    out_ready[i] = 1'b1;
    @(negedge clk);
    out_ready[i] = 1'b0;
    check({tag, " valid drops"}, 32'(out_valid[i]), 32'd0);
    check({tag, " idle ready"}, 32'(in_ready[i]), 32'd1);
    check({tag, " data kept"}, out_data[i], exp);
  endtask

  initial begin
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      in_shamt[i]  = '0;
      in_op[i]     = OP_SLL;
      out_ready[i] = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset valid%0d", i), 32'(out_valid[i]), 32'd0);
      check($sformatf("reset ready%0d", i), 32'(in_ready[i]), 32'd1);
      check($sformatf("reset data%0d", i), out_data[i], 32'd0);
    end
    rst_n = 1'b1;

    // Directed cases on the STEP=4 instance.
    run_op(1, 32'h0000_0001, 5'd2,  OP_SLL, 0, "sll1by2");
    run_op(1, 32'h8000_0000, 5'd31, OP_SRA, 0, "sra31");
    run_op(1, 32'h8000_0000, 5'd31, OP_SRL, 0, "srl31");
    run_op(1, 32'hA5A5_5A5A, 5'd0,  OP_SRA, 5, "shamt0");
    run_op(1, 32'h8000_0001, 5'd4,  OP_ROL, 1, "op11");
`ifdef SEQ_SHIFTER_ROTATE_EN
    check("op11 literal", ref_shift(32'h8000_0001, 4, OP_ROL), 32'h0000_0018);
`else
    check("op11 literal", ref_shift(32'h8000_0001, 4, OP_ROL), 32'h0000_0010);
`endif
    run_op(0, 32'h8000_0000, 5'd31, OP_SRA, 2, "sra31 step1");
    run_op(2, 32'h8765_4321, 5'd17, OP_SRA, 2, "sra17 step32");

    // Reset in the middle of a long shift.
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_data[1]  = 32'h0000_0001;
    in_shamt[1] = 5'd31;
    in_op[1]    = OP_SLL;
    @(negedge clk);
    in_valid[1] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst valid", 32'(out_valid[1]), 32'd0);
    check("midrst ready", 32'(in_ready[1]), 32'd1);
    check("midrst data", out_data[1], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("midrst no stale", 32'(out_valid[1]), 32'd0);
    end
    run_op(1, 32'hF000_000F, 5'd8, OP_SRL, 0, "after midrst");

    // Random operations on every instance.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < NRAND; n++) begin
        run_op(i, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), -1,
               $sformatf("rand s%0d", step_of(i)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
